// File: rtl/sync_fifo_flags_if.sv
// Write/read handshake, status and data bundle for one sync_fifo_flags instance.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  cs;
    logic                  wr_en;
    logic                  rd_en;
    logic                  flush;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic [AW:0]           count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output cs, wr_en, rd_en, flush, data_in,
        input  data_out, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  cs, wr_en, rd_en, flush, data_in,
        output data_out, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors and flush.
// Flags update on the accepting edge; FWFT=1 shows data next cycle, FWFT=0 one cycle after the read; full/empty reject and flag.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    sync_fifo_flags_if.slave    bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] AF_T    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_T    = (AW+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           occ;
    logic                  is_empty;
    logic                  is_full;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic                  overflow_q;
    logic                  underflow_q;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign occ      = wr_ptr - rd_ptr;
    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign wr_acc = bus.cs && bus.wr_en && !is_full  && !bus.flush;
    assign rd_acc = bus.cs && bus.rd_en && !is_empty && !bus.flush;
    assign wr_rej = bus.cs && bus.wr_en &&  is_full  && !bus.flush;
    assign rd_rej = bus.cs && bus.rd_en &&  is_empty && !bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_rej) begin
                overflow_q <= 1'b1;
            end
            if (rd_rej) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.count        = occ;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (occ >= AF_T);
    assign bus.almost_empty = (occ <= AE_T);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    generate
        if (FWFT) begin : g_fwft
            assign bus.data_out = mem[rd_ptr[AW-1:0]];
            assign bus.rd_valid = !is_empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_q;
            logic                  rd_valid_q;

            // data_q keeps the last word read, including across a flush.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else if (bus.flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= mem[rd_ptr[AW-1:0]];
                    end
                end
            end

            assign bus.data_out = data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: a vector table for fill/drain/flags on an FWFT instance, hand sequences
// for registered reads, pointer wrap, flush and asynchronous reset.
module tb_sync_fifo_flags;
    logic clk;
    logic reset_n;

    sync_fifo_flags_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) if1 ();
    sync_fifo_flags_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) if0 ();

    sync_fifo_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1.slave)
    );

    sync_fifo_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ctl = {cs, wr_en, rd_en, flush}; flg = {empty, full, af, ae, ovf, udf, rd_valid, check_dout}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] din;
        logic [3:0]  cnt;
        logic [7:0]  flg;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] din,
                                input logic [3:0] cnt, input logic [7:0] flg,
                                input logic [31:0] dout);
        vec_t v;
        v.ctl  = ctl;
        v.din  = din;
        v.cnt  = cnt;
        v.flg  = flg;
        v.dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic [3:0] ctl, input logic [31:0] din);
        if1.cs      = ctl[3];
        if1.wr_en   = ctl[2];
        if1.rd_en   = ctl[1];
        if1.flush   = ctl[0];
        if1.data_in = din;
    endtask

    task automatic drive0(input logic [3:0] ctl, input logic [31:0] din);
        if0.cs      = ctl[3];
        if0.wr_en   = ctl[2];
        if0.rd_en   = ctl[1];
        if0.flush   = ctl[0];
        if0.data_in = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " fwft count"},   32'(if1.count), 32'd0);
        chk({tag, " fwft empty"},   32'(if1.empty), 32'd1);
        chk({tag, " fwft full"},    32'(if1.full), 32'd0);
        chk({tag, " fwft af"},      32'(if1.almost_full), 32'd0);
        chk({tag, " fwft ae"},      32'(if1.almost_empty), 32'd1);
        chk({tag, " fwft ovf"},     32'(if1.overflow), 32'd0);
        chk({tag, " fwft udf"},     32'(if1.underflow), 32'd0);
        chk({tag, " fwft rdv"},     32'(if1.rd_valid), 32'd0);
        chk({tag, " reg count"},    32'(if0.count), 32'd0);
        chk({tag, " reg empty"},    32'(if0.empty), 32'd1);
        chk({tag, " reg ae"},       32'(if0.almost_empty), 32'd1);
        chk({tag, " reg rdv"},      32'(if0.rd_valid), 32'd0);
        chk({tag, " reg dout"},     if0.data_out, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] p;

        // Fill, overflow, cs gating, drain, underflow, flush with cs low
        tbl[0]  = mk(4'b1100, 32'hA0, 4'd1, 8'b0001_0011, 32'hA0);
        tbl[1]  = mk(4'b1100, 32'hA1, 4'd2, 8'b0001_0011, 32'hA0);
        tbl[2]  = mk(4'b1100, 32'hA2, 4'd3, 8'b0000_0011, 32'hA0);
        tbl[3]  = mk(4'b1100, 32'hA3, 4'd4, 8'b0000_0011, 32'hA0);
        tbl[4]  = mk(4'b1100, 32'hA4, 4'd5, 8'b0000_0011, 32'hA0);
        tbl[5]  = mk(4'b1100, 32'hA5, 4'd6, 8'b0010_0011, 32'hA0);
        tbl[6]  = mk(4'b1100, 32'hA6, 4'd7, 8'b0010_0011, 32'hA0);
        tbl[7]  = mk(4'b1100, 32'hA7, 4'd8, 8'b0110_0011, 32'hA0);
        tbl[8]  = mk(4'b1100, 32'hFF, 4'd8, 8'b0110_1011, 32'hA0);
        tbl[9]  = mk(4'b0110, 32'h55, 4'd8, 8'b0110_1011, 32'hA0);
        tbl[10] = mk(4'b1010, 32'h00, 4'd7, 8'b0010_1011, 32'hA1);
        tbl[11] = mk(4'b1010, 32'h00, 4'd6, 8'b0010_1011, 32'hA2);
        tbl[12] = mk(4'b1010, 32'h00, 4'd5, 8'b0000_1011, 32'hA3);
        tbl[13] = mk(4'b1010, 32'h00, 4'd4, 8'b0000_1011, 32'hA4);
        tbl[14] = mk(4'b1010, 32'h00, 4'd3, 8'b0000_1011, 32'hA5);
        tbl[15] = mk(4'b1010, 32'h00, 4'd2, 8'b0001_1011, 32'hA6);
        tbl[16] = mk(4'b1010, 32'h00, 4'd1, 8'b0001_1011, 32'hA7);
        tbl[17] = mk(4'b1010, 32'h00, 4'd0, 8'b1001_1000, 32'h00);
        tbl[18] = mk(4'b1010, 32'h00, 4'd0, 8'b1001_1100, 32'h00);
        tbl[19] = mk(4'b0101, 32'h77, 4'd0, 8'b1001_0000, 32'h00);

        reset_n = 1'b0;
        drive1(4'b0000, 32'h0);
        drive0(4'b0000, 32'h0);
        #12;
        chk_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive1(tbl[i].ctl, tbl[i].din);
            tick();
            chk($sformatf("vec%0d count", i), 32'(if1.count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d empty", i), 32'(if1.empty), 32'(tbl[i].flg[7]));
            chk($sformatf("vec%0d full", i),  32'(if1.full), 32'(tbl[i].flg[6]));
            chk($sformatf("vec%0d af", i),    32'(if1.almost_full), 32'(tbl[i].flg[5]));
            chk($sformatf("vec%0d ae", i),    32'(if1.almost_empty), 32'(tbl[i].flg[4]));
            chk($sformatf("vec%0d ovf", i),   32'(if1.overflow), 32'(tbl[i].flg[3]));
            chk($sformatf("vec%0d udf", i),   32'(if1.underflow), 32'(tbl[i].flg[2]));
            chk($sformatf("vec%0d rdv", i),   32'(if1.rd_valid), 32'(tbl[i].flg[1]));
            if (tbl[i].flg[0]) begin
                chk($sformatf("vec%0d dout", i), if1.data_out, tbl[i].dout);
            end
        end
        @(negedge clk);
        drive1(4'b0000, 32'h0);

        // Registered read mode: back-to-back reads, hold, flush keeps data_out
        @(negedge clk); drive0(4'b1100, 32'h11); tick();
        chk("reg w1 rdv", 32'(if0.rd_valid), 32'd0);
        chk("reg w1 count", 32'(if0.count), 32'd1);
        @(negedge clk); drive0(4'b1100, 32'h22); tick();
        chk("reg w2 count", 32'(if0.count), 32'd2);
        @(negedge clk); drive0(4'b1010, 32'h0); tick();
        chk("reg r1 rdv", 32'(if0.rd_valid), 32'd1);
        chk("reg r1 dout", if0.data_out, 32'h11);
        @(negedge clk); drive0(4'b1010, 32'h0); tick();
        chk("reg r2 rdv", 32'(if0.rd_valid), 32'd1);
        chk("reg r2 dout", if0.data_out, 32'h22);
        chk("reg r2 empty", 32'(if0.empty), 32'd1);
        @(negedge clk); drive0(4'b0000, 32'h0); tick();
        chk("reg idle rdv", 32'(if0.rd_valid), 32'd0);
        chk("reg idle dout", if0.data_out, 32'h22);
        @(negedge clk); drive0(4'b1100, 32'h33); tick();
        @(negedge clk); drive0(4'b1010, 32'h0); tick();
        chk("reg r3 dout", if0.data_out, 32'h33);
        @(negedge clk); drive0(4'b1100, 32'h44); tick();
        @(negedge clk); drive0(4'b1011, 32'h0); tick();
        chk("reg flush rdv", 32'(if0.rd_valid), 32'd0);
        chk("reg flush dout", if0.data_out, 32'h33);
        chk("reg flush count", 32'(if0.count), 32'd0);
        @(negedge clk); drive0(4'b0000, 32'h0);

        // Concurrent read/write at count 3 across the pointer wrap
        p = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive1(4'b1100, p); q.push_back(p); p++; tick();
        end
        chk("wrap pre count", 32'(if1.count), 32'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); drive1(4'b1110, p);
            chk($sformatf("wrap%0d dout", i), if1.data_out, q[0]);
            tick();
            void'(q.pop_front()); q.push_back(p); p++;
            chk($sformatf("wrap%0d count", i), 32'(if1.count), 32'd3);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive1(4'b1100, p); q.push_back(p); p++; tick();
        end
        chk("wrap full", 32'(if1.full), 32'd1);
        @(negedge clk); drive1(4'b1110, 32'hDEAD); tick();
        void'(q.pop_front());
        chk("both@full count", 32'(if1.count), 32'd7);
        chk("both@full ovf", 32'(if1.overflow), 32'd1);
        chk("both@full dout", if1.data_out, q[0]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive1(4'b1010, 32'h0); tick();
            void'(q.pop_front());
        end
        chk("pre-flush count", 32'(if1.count), 32'd5);
        chk("pre-flush dout", if1.data_out, q[0]);

        // Flush with a write in the same cycle
        @(negedge clk); drive1(4'b1101, 32'hEE); tick();
        chk("flush count", 32'(if1.count), 32'd0);
        chk("flush empty", 32'(if1.empty), 32'd1);
        chk("flush ovf", 32'(if1.overflow), 32'd0);
        @(negedge clk); drive1(4'b1100, 32'h12); tick();
        chk("post-flush count", 32'(if1.count), 32'd1);
        chk("post-flush dout", if1.data_out, 32'h12);

        // Asynchronous reset between edges with count 4
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive1(4'b1100, 32'h20 + 32'(i)); tick();
        end
        @(negedge clk); drive1(4'b0000, 32'h0);
        chk("pre-reset count", 32'(if1.count), 32'd4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset("async");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); drive1(4'b1100, 32'h5A); drive0(4'b1100, 32'h5A); tick();
        chk("rst fwft dout", if1.data_out, 32'h5A);
        chk("rst fwft rdv", 32'(if1.rd_valid), 32'd1);
        chk("rst fwft count", 32'(if1.count), 32'd1);
        @(negedge clk); drive1(4'b1010, 32'h0); drive0(4'b1010, 32'h0); tick();
        chk("rst fwft empty", 32'(if1.empty), 32'd1);
        chk("rst reg rdv", 32'(if0.rd_valid), 32'd1);
        chk("rst reg dout", if0.data_out, 32'h5A);
        @(negedge clk); drive1(4'b0000, 32'h0); drive0(4'b0000, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
